// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid bit, hazard stall/flush and event counters.
// Optional: define CLEAR_DATA_ON_FLUSH_EN to zero data/dst on a flush bubble.
module pipe_stage_reg #(
  parameter int CTRL_W   = 3,
  parameter int DWL      = 32,
  parameter int NUM_DATA = 2,
  parameter int AWL      = 6,
  parameter int CNT_W    = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    STALL,
  input  logic                    FLUSH,
  input  logic                    CNT_CLR,
  input  logic                    VALID_IN,
  input  logic [CTRL_W-1:0]       CTRL_IN,
  input  logic [NUM_DATA*DWL-1:0] DATA_IN,
  input  logic [AWL-2:0]          DST_IN,
  output logic                    VALID_OUT,
  output logic [CTRL_W-1:0]       CTRL_OUT,
  output logic [NUM_DATA*DWL-1:0] DATA_OUT,
  output logic [AWL-2:0]          DST_OUT,
  output logic [CNT_W-1:0]        STALL_CNT,
  output logic [CNT_W-1:0]        FLUSH_CNT
);

  if (NUM_DATA < 1 || NUM_DATA > 4 || CNT_W < 1) begin : g_param_err
    $error("pipe_stage_reg: NUM_DATA must be 1..4 and CNT_W >= 1");
  end

  logic                    r_valid;
  logic [CTRL_W-1:0]       r_ctrl;
  logic [NUM_DATA*DWL-1:0] r_data;
  logic [AWL-2:0]          r_dst;
  logic [CNT_W-1:0]        r_stall_cnt;
  logic [CNT_W-1:0]        r_flush_cnt;

  logic [CTRL_W-1:0] w_ctrl_ld;
  logic              w_stall_ev;
  logic              w_flush_ev;
  logic              w_stall_sat;
  logic              w_flush_sat;

  // Invalid instructions never carry asserted control downstream.
  assign w_ctrl_ld   = VALID_IN ? CTRL_IN : '0;
  assign w_stall_ev  = STALL & ~FLUSH;
  assign w_flush_ev  = FLUSH & r_valid;
  assign w_stall_sat = &r_stall_cnt;
  assign w_flush_sat = &r_flush_cnt;

  // Valid/control: flush inserts a bubble, stall holds, otherwise load.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (FLUSH) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (!STALL) begin
      r_valid <= VALID_IN;
      r_ctrl  <= w_ctrl_ld;
    end
  end

  // Data/destination: held on flush unless bubbles are fully cleared.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_data <= '0;
      r_dst  <= '0;
`ifdef CLEAR_DATA_ON_FLUSH_EN
    end else if (FLUSH) begin
      r_data <= '0;
      r_dst  <= '0;
`else
    end else if (FLUSH) begin
      r_data <= r_data;
      r_dst  <= r_dst;
`endif
    end else if (!STALL) begin
      r_data <= DATA_IN;
      r_dst  <= DST_IN;
    end
  end

  // Stall-cycle counter, saturating; clear wins over increment.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall_cnt <= '0;
    end else if (CNT_CLR) begin
      r_stall_cnt <= '0;
    end else if (w_stall_ev && !w_stall_sat) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Killed-instruction counter; flushing a bubble is not counted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_flush_cnt <= '0;
    end else if (CNT_CLR) begin
      r_flush_cnt <= '0;
    end else if (w_flush_ev && !w_flush_sat) begin
      r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign VALID_OUT = r_valid;
  assign CTRL_OUT  = r_ctrl;
  assign DATA_OUT  = r_data;
  assign DST_OUT   = r_dst;
  assign STALL_CNT = r_stall_cnt;
  assign FLUSH_CNT = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed vectors on default and
// small-counter builds, plus a modelled load/stall/flush run on a narrow build.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, cnt_clr, vin;
  logic [2:0]  ctrl_in;
  logic [63:0] data_in;
  logic [4:0]  dst_in;

  logic        a_valid, b_valid;
  logic [2:0]  a_ctrl, b_ctrl;
  logic [63:0] a_data, b_data;
  logic [4:0]  a_dst, b_dst;
  logic [15:0] a_scnt, a_fcnt;
  logic [3:0]  b_scnt, b_fcnt;

  logic        c_stall, c_flush, c_clr, c_vin;
  logic [4:0]  c_ctrl_in;
  logic [31:0] c_data_in;
  logic [4:0]  c_dst_in;
  logic        c_valid;
  logic [4:0]  c_ctrl;
  logic [31:0] c_data;
  logic [4:0]  c_dst;
  logic [15:0] c_scnt, c_fcnt;

  always #5 clk = ~clk;

  pipe_stage_reg u_a (
    .CLK(clk), .RST_N(rst_n), .STALL(stall), .FLUSH(flush),
    .CNT_CLR(cnt_clr), .VALID_IN(vin), .CTRL_IN(ctrl_in),
    .DATA_IN(data_in), .DST_IN(dst_in), .VALID_OUT(a_valid),
    .CTRL_OUT(a_ctrl), .DATA_OUT(a_data), .DST_OUT(a_dst),
    .STALL_CNT(a_scnt), .FLUSH_CNT(a_fcnt)
  );

  pipe_stage_reg #(.CNT_W(4)) u_b (
    .CLK(clk), .RST_N(rst_n), .STALL(stall), .FLUSH(flush),
    .CNT_CLR(cnt_clr), .VALID_IN(vin), .CTRL_IN(ctrl_in),
    .DATA_IN(data_in), .DST_IN(dst_in), .VALID_OUT(b_valid),
    .CTRL_OUT(b_ctrl), .DATA_OUT(b_data), .DST_OUT(b_dst),
    .STALL_CNT(b_scnt), .FLUSH_CNT(b_fcnt)
  );

  pipe_stage_reg #(.NUM_DATA(1), .CTRL_W(5), .AWL(6)) u_c (
    .CLK(clk), .RST_N(rst_n), .STALL(c_stall), .FLUSH(c_flush),
    .CNT_CLR(c_clr), .VALID_IN(c_vin), .CTRL_IN(c_ctrl_in),
    .DATA_IN(c_data_in), .DST_IN(c_dst_in), .VALID_OUT(c_valid),
    .CTRL_OUT(c_ctrl), .DATA_OUT(c_data), .DST_OUT(c_dst),
    .STALL_CNT(c_scnt), .FLUSH_CNT(c_fcnt)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  event chk_now;

  function automatic logic [63:0] peek(int sel);
    case (sel)
      0:  peek = 64'(a_valid);
      1:  peek = 64'(a_ctrl);
      2:  peek = a_data;
      3:  peek = 64'(a_dst);
      4:  peek = 64'(a_scnt);
      5:  peek = 64'(a_fcnt);
      10: peek = 64'(b_valid);
      14: peek = 64'(b_scnt);
      15: peek = 64'(b_fcnt);
      20: peek = 64'(c_valid);
      21: peek = 64'(c_ctrl);
      22: peek = 64'(c_data);
      23: peek = 64'(c_dst);
      24: peek = 64'(c_scnt);
      25: peek = 64'(c_fcnt);
      29: peek = 64'(!c_valid && (c_ctrl != 5'd0));
      default: peek = 64'hX;
    endcase
  endfunction

  task automatic push(string n, int sel, logic [63:0] e);
    chk_t c;
    c.name = n;
    c.sel  = sel;
    c.exp  = e;
    q.push_back(c);
  endtask

  task automatic push_a(string tag, logic v, logic [2:0] c,
                        logic [63:0] d, logic [4:0] ds,
                        logic [15:0] sc, logic [15:0] fc);
    push({tag, ".valid"}, 0, 64'(v));
    push({tag, ".ctrl"},  1, 64'(c));
    push({tag, ".data"},  2, d);
    push({tag, ".dst"},   3, 64'(ds));
    push({tag, ".scnt"},  4, 64'(sc));
    push({tag, ".fcnt"},  5, 64'(fc));
  endtask

  // Monitor: drain pending expectations when outputs are stable.
  always @(negedge clk or chk_now) begin
    while (q.size() > 0) begin
      chk_t        c;
      logic [63:0] act;
      c   = q.pop_front();
      act = peek(c.sel);
      n_vec++;
      if (act !== c.exp) begin
        n_miss++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic        m_valid;
  logic [4:0]  m_ctrl, m_dst;
  logic [31:0] m_data;
  logic [15:0] m_scnt, m_fcnt;
  logic [63:0] hold_d;

  initial begin
    rst_n   = 1'b0;
    stall   = 1'b1; flush = 1'b1; cnt_clr = 1'b1; vin = 1'b1;
    ctrl_in = '1;   data_in = '1; dst_in = '1;
    c_stall = 1'b1; c_flush = 1'b1; c_clr = 1'b1; c_vin = 1'b1;
    c_ctrl_in = '1; c_data_in = '1; c_dst_in = '1;

    // 1. reset with inputs all ones, then release before an edge
    tick(); tick();
    push_a("rst", 0, 0, 0, 0, 0, 0);
    push("rst.b_scnt", 14, 0);
    push("rst.c_valid", 20, 0);
    rst_n = 1'b1;
    stall = 0; flush = 0; cnt_clr = 0; vin = 0;
    ctrl_in = 0; data_in = 0; dst_in = 0;
    c_stall = 0; c_flush = 0; c_clr = 0; c_vin = 0;
    c_ctrl_in = 0; c_data_in = 0; c_dst_in = 0;
    push_a("rel", 0, 0, 0, 0, 0, 0);
    push("rel.c_data", 22, 0);

    // 2. load then stall three edges with changed inputs
    vin = 1; ctrl_in = 3'b101;
    data_in = {32'hDEADBEEF, 32'h00000010}; dst_in = 5'd9;
    tick();
    push_a("load", 1, 3'b101, 64'hDEADBEEF_00000010, 9, 0, 0);
    stall = 1; vin = 0; ctrl_in = 3'b010;
    data_in = 64'h0123_4567_89AB_CDEF; dst_in = 5'd3;
    tick(); tick(); tick();
    push_a("stall3", 1, 3'b101, 64'hDEADBEEF_00000010, 9, 3, 0);

    // 3. flush together with stall, then flush the bubble
    stall = 0; vin = 1; ctrl_in = 3'b011;
    data_in = 64'h1111_2222_3333_4444; dst_in = 5'd17;
    tick();
    push_a("load2", 1, 3'b011, 64'h1111_2222_3333_4444, 17, 3, 0);
    stall = 1; flush = 1;
    tick();
`ifdef CLEAR_DATA_ON_FLUSH_EN
    push_a("flush", 0, 0, 0, 0, 3, 1);
`else
    push_a("flush", 0, 0, 64'h1111_2222_3333_4444, 17, 3, 1);
`endif
    stall = 0;
    tick();
    push("flush2.fcnt", 5, 1);
    push("flush2.valid", 0, 0);
    push("flush2.scnt", 4, 3);

    // 4. invalid load still carries data but no control
    flush = 0; vin = 0; ctrl_in = 3'b111;
    data_in = 64'hCAFE_0000_0000_BABE; dst_in = 5'd5;
    tick();
    push_a("inval", 0, 0, 64'hCAFE_0000_0000_BABE, 5, 3, 1);

    // 1b. asynchronous reset mid-cycle while valid
    vin = 1; ctrl_in = 3'b001; data_in = 64'h55; dst_in = 5'd2;
    tick();
    push_a("pre_arst", 1, 3'b001, 64'h55, 2, 3, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    push_a("arst", 0, 0, 0, 0, 0, 0);
    -> chk_now;
    tick();
    rst_n = 1'b1;
    vin = 0; ctrl_in = 0; data_in = 0; dst_in = 0;

    // 5. saturation on the 4-bit counter build, then clear vs stall
    stall = 1;
    repeat (20) tick();
    push("sat.b_scnt", 14, 15);
    push("sat.a_scnt", 4, 20);
    cnt_clr = 1;
    tick();
    push("clr.b_scnt", 14, 0);
    push("clr.a_scnt", 4, 0);
    push("clr.b_fcnt", 15, 0);
    cnt_clr = 0;
    tick();
    push("resume.b_scnt", 14, 1);
    stall = 0;

    // 6. narrow build against a reference model
    m_valid = 0; m_ctrl = 0; m_data = 0; m_dst = 0;
    m_scnt = 0; m_fcnt = 0;
    for (int i = 0; i < 1000; i++) begin
      c_stall   = ($urandom_range(0, 3) == 0);
      c_flush   = ($urandom_range(0, 6) == 0);
      c_clr     = ($urandom_range(0, 40) == 0);
      c_vin     = $urandom_range(0, 1) == 1;
      c_ctrl_in = 5'($urandom);
      c_data_in = $urandom;
      c_dst_in  = 5'($urandom);
      if (c_clr) begin
        m_scnt = 0;
        m_fcnt = 0;
      end else begin
        if (c_stall && !c_flush && m_scnt != 16'hFFFF) m_scnt++;
        if (c_flush && m_valid && m_fcnt != 16'hFFFF) m_fcnt++;
      end
      if (c_flush) begin
        m_valid = 0;
        m_ctrl  = 0;
`ifdef CLEAR_DATA_ON_FLUSH_EN
        m_data  = 0;
        m_dst   = 0;
`endif
      end else if (!c_stall) begin
        m_valid = c_vin;
        m_ctrl  = c_vin ? c_ctrl_in : 5'd0;
        m_data  = c_data_in;
        m_dst   = c_dst_in;
      end
      tick();
      push("rnd.valid", 20, 64'(m_valid));
      push("rnd.ctrl",  21, 64'(m_ctrl));
      push("rnd.data",  22, 64'(m_data));
      push("rnd.dst",   23, 64'(m_dst));
      push("rnd.scnt",  24, 64'(m_scnt));
      push("rnd.fcnt",  25, 64'(m_fcnt));
      push("rnd.inv",   29, 0);
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    hold_d = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
